csi_rx_frame_ctrl: RTL and testbench
====================================

# csi_rx_frame_ctrl

Frame-level sequencer that sits beside the CSI-2 receive packet handler. It watches the handler's vsync / in_frame / in_line / payload_enable outputs, gates captured payload to downstream logic one whole frame at a time, and checks line length and line count. It runs a watchdog during capture. On a stall it pulses a recovery reset into the packet handler and byte/word aligners, then re-synchronises on the next Frame Start.

## Interface
- EXP_LINES, 16'd480, expected video lines per frame
- EXP_WORDS, 16'd160, expected 32-bit payload words per line (ceil(line bytes / 4))
- TIMEOUT, 24'd65535, max cycles without activity while capturing
- RESET_CYCLES, 4'd4, length of rx_reset pulse during recovery (must be ≥1)
- clock  in  1  byte/word clock, same domain as packet handler
- reset  in  1  synchronous, active-high reset
- enable  in  1  active-high clock enable; when low, all state and outputs hold
- arm  in  1  single-shot request: capture the next frame
- continuous  in  1  level; capture every frame while high
- clear_err  in  1  pulse; clears err_flags
- vsync  in  1  FS pulse from packet handler
- in_frame  in  1  from packet handler
- in_line  in  1  from packet handler
- payload_enable  in  1  from packet handler
- rx_reset  out  1  reset to packet handler/aligners (ORed with system reset externally)
- capture_enable  out  1  qualifies payload for downstream
- frame_start  out  1  one-cycle pulse at accepted FS
- frame_done  out  1  one-cycle pulse, frame ended with no error
- frame_error  out  1  one-cycle pulse, frame ended or aborted with error
- line_count  out  16  lines completed in the current or last frame
- err_flags  out  4  sticky: [0] line length, [1] line count, [2] timeout, [3] FS without FE
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT_FS, CAPTURE, RECOVER.
- IDLE: capture_enable=0.
  - If arm=1 or continuous=1, go to WAIT_FS.
  - arm is ignored in any other state.
- WAIT_FS: waits indefinitely for vsync=1.
  - On vsync: pulse frame_start, clear line_count, the word counter, the watchdog and the per-frame error bit, then go to CAPTURE.
- CAPTURE: capture_enable=1.
  - Word counter: 16-bit, saturating; increments on payload_enable && in_line.
  - Line end: in_line falling edge, detected against a registered copy.
    - line_count increments (16-bit, wraps).
    - If word count ≠ EXP_WORDS, set err_flags[0] and the per-frame error bit.
    - Word counter clears.
  - Frame end: in_frame falling edge.
    - If line_count (including a line ending in the same cycle) ≠ EXP_LINES, set err_flags[1].
    - Pulse frame_done, or frame_error if the per-frame error bit is set.
    - Next state: WAIT_FS if continuous, else IDLE.
  - vsync while in CAPTURE (missing FE):
    - Set err_flags[3] and pulse frame_error.
    - Then behave exactly as an FS accepted in WAIT_FS, pulsing frame_start in the same cycle; stay in CAPTURE.
  - Watchdog: 24-bit.
    - Clears on any payload_enable, in_line edge, in_frame edge or vsync; otherwise increments.
    - Reaching TIMEOUT: set err_flags[2], pulse frame_error, go to RECOVER.
- RECOVER:
  - rx_reset=1 and capture_enable=0 for exactly RESET_CYCLES cycles.
  - Then go to WAIT_FS if continuous, else IDLE.
- err_flags are sticky until a clear_err pulse. If clear_err and a new error occur in the same cycle, the new error bit ends up set.
- line_count holds its last value in IDLE and WAIT_FS.

## Timing
- Reset values: state IDLE, rx_reset=0, capture_enable=0, frame_start/frame_done/frame_error=0, line_count=0, err_flags=0, busy=0.
- All outputs are registered: 1-cycle latency from the causing input sample.
- capture_enable rises the cycle after vsync is sampled and falls the cycle after the in_frame falling edge is sampled.
- Pulses are one enabled cycle wide.
- frame_start and frame_error may coincide (FS without FE). frame_done and frame_error never coincide.
- Priority within CAPTURE, highest first: timeout, vsync, frame end, line end.
- Reset during any state returns to IDLE next cycle. An rx_reset in progress is dropped immediately.
- continuous falling mid-frame: the current frame completes, then the block goes to IDLE.

## Test plan
- Nominal single-shot:
  - Stimulus: EXP_LINES=4, EXP_WORDS=3; arm, then FS, then 4 lines of 3 words each, then FE.
  - Required: frame_start once; capture_enable high from FS+1 to FE+1; frame_done once; line_count=4; err_flags=0; back to IDLE.
- Short line:
  - Stimulus: same frame as above, but line 2 has 2 words.
  - Required: err_flags=4'b0001 and a frame_error pulse, with no frame_done pulse. After clear_err, err_flags=0.
- Wrong line count, continuous:
  - Stimulus: continuous=1; frame with 3 lines, followed by a good frame.
  - Required: first frame gives err_flags[1]=1 and frame_error; second frame gives frame_done; state stays WAIT_FS/CAPTURE.
- Timeout:
  - Stimulus: TIMEOUT=20, RESET_CYCLES=4; FS, then stall.
  - Required: frame_error at the 20th idle cycle; rx_reset high for exactly 4 cycles; err_flags[2]=1; then WAIT_FS.
- FS without FE:
  - Stimulus: second vsync mid-frame.
  - Required: frame_error and frame_start in the same cycle; err_flags[3]=1; line_count restarts at 0.
- Reset and enable:
  - Stimulus: hold enable low for 10 cycles mid-line, then assert reset during RECOVER.
  - Required: while enable is low, counters and outputs hold. After reset, rx_reset=0 next cycle and all outputs are at their reset values.

Source files
------------

// File: rtl/csi_rx_frame_ctrl_if.sv
// csi_rx_frame_ctrl_if: signal bundle between the CSI-2 packet handler / host
// control and the frame-level sequencer.
//   control : enable, arm, continuous, clear_err               (to sequencer)
//   handler : vsync, in_frame, in_line, payload_enable         (to sequencer)
//   results : rx_reset, capture_enable, frame_start, frame_done,
//             frame_error, line_count[15:0], err_flags[3:0], busy (from sequencer)
interface csi_rx_frame_ctrl_if;
  localparam int unsigned LINE_W = 16;
  localparam int unsigned ERR_W  = 4;

  logic              enable;
  logic              arm;
  logic              continuous;
  logic              clear_err;
  logic              vsync;
  logic              in_frame;
  logic              in_line;
  logic              payload_enable;
  logic              rx_reset;
  logic              capture_enable;
  logic              frame_start;
  logic              frame_done;
  logic              frame_error;
  logic [LINE_W-1:0] line_count;
  logic [ERR_W-1:0]  err_flags;
  logic              busy;

  // Driver side: control and packet-handler status.
  modport master (
    output enable, arm, continuous, clear_err,
    output vsync, in_frame, in_line, payload_enable,
    input  rx_reset, capture_enable, frame_start, frame_done, frame_error,
    input  line_count, err_flags, busy
  );

  // Sequencer side.
  modport slave (
    input  enable, arm, continuous, clear_err,
    input  vsync, in_frame, in_line, payload_enable,
    output rx_reset, capture_enable, frame_start, frame_done, frame_error,
    output line_count, err_flags, busy
  );
endinterface

// File: rtl/csi_rx_frame_ctrl.sv
// csi_rx_frame_ctrl: frame-level sequencer beside the CSI-2 packet handler.
// Gates payload one whole frame at a time, checks words per line and lines per
// frame, runs a watchdog while capturing and, on a stall, pulses rx_reset into
// the handler/aligners before re-synchronising on the next Frame Start.
// Ports:
//   clock         byte/word clock
//   reset         synchronous active-high reset
//   bus (slave)   enable/arm/continuous/clear_err, vsync/in_frame/in_line/
//                 payload_enable in; rx_reset, capture_enable, frame_start,
//                 frame_done, frame_error, line_count, err_flags, busy out
module csi_rx_frame_ctrl #(
  parameter logic [15:0] EXP_LINES    = 16'd480,
  parameter logic [15:0] EXP_WORDS    = 16'd160,
  parameter logic [23:0] TIMEOUT      = 24'd65535,
  parameter logic [3:0]  RESET_CYCLES = 4'd4
) (
  input logic            clock,
  input logic            reset,
  csi_rx_frame_ctrl_if.slave bus
);
  localparam int unsigned LINE_W = 16;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned WD_W   = 24;
  localparam int unsigned RST_W  = 4;
  localparam int unsigned ERR_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FS = 2'd1,
    CAPTURE = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              in_line_q, in_frame_q;
  logic [WORD_W-1:0] words_q, words_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [RST_W-1:0]  rcnt_q, rcnt_d;
  logic              perr_q, perr_d;
  logic [LINE_W-1:0] lines_q, lines_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              rx_reset_q, rx_reset_d;
  logic              cap_q, cap_d;
  logic              fs_q, fs_d;
  logic              fd_q, fd_d;
  logic              fe_q, fe_d;
  logic              busy_q, busy_d;

  logic              line_end, frame_end, activity;
  logic              len_bad, cnt_bad;
  logic [ERR_W-1:0]  err_new;

  // Edge detection against the registered copies of the handler strobes.
  assign line_end  = in_line_q & ~bus.in_line;
  assign frame_end = in_frame_q & ~bus.in_frame;
  assign activity  = bus.payload_enable | (bus.in_line ^ in_line_q) |
                     (bus.in_frame ^ in_frame_q) | bus.vsync;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    wd_d    = wd_q;
    rcnt_d  = rcnt_q;
    perr_d  = perr_q;
    lines_d = lines_q;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    fe_d    = 1'b0;
    err_new = '0;
    len_bad = 1'b0;
    cnt_bad = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.arm || bus.continuous) state_d = WAIT_FS;
      end
      WAIT_FS: begin
        if (bus.vsync) begin
          state_d = CAPTURE;
          fs_d    = 1'b1;
          lines_d = '0;
          words_d = '0;
          wd_d    = '0;
          perr_d  = 1'b0;
        end
      end
      CAPTURE: begin
        if (!activity && (wd_q >= TIMEOUT - WD_W'(1))) begin
          // Stall: abort the frame and reset the receive path.
          err_new[2] = 1'b1;
          fe_d       = 1'b1;
          state_d    = RECOVER;
          rcnt_d     = RESET_CYCLES - RST_W'(1);
        end else if (bus.vsync) begin
          // Frame Start without Frame End: report and restart the frame.
          err_new[3] = 1'b1;
          fe_d       = 1'b1;
          fs_d       = 1'b1;
          lines_d    = '0;
          words_d    = '0;
          wd_d       = '0;
          perr_d     = 1'b0;
        end else begin
          wd_d = activity ? '0 : wd_q + WD_W'(1);
          if (bus.payload_enable && bus.in_line && (words_q != '1))
            words_d = words_q + WORD_W'(1);
          if (line_end) begin
            lines_d = lines_q + LINE_W'(1);
            words_d = '0;
            if (words_q != EXP_WORDS) begin
              len_bad    = 1'b1;
              err_new[0] = 1'b1;
            end
          end
          perr_d = perr_q | len_bad;
          if (frame_end) begin
            // lines_d already counts a line closing in this same cycle.
            if (lines_d != EXP_LINES) begin
              cnt_bad    = 1'b1;
              err_new[1] = 1'b1;
            end
            if (perr_q || len_bad || cnt_bad) fe_d = 1'b1;
            else                              fd_d = 1'b1;
            state_d = bus.continuous ? WAIT_FS : IDLE;
          end
        end
      end
      RECOVER: begin
        if (rcnt_q == '0) state_d = bus.continuous ? WAIT_FS : IDLE;
        else              rcnt_d  = rcnt_q - RST_W'(1);
      end
    endcase

    // A new error wins over a simultaneous clear.
    err_d      = (bus.clear_err ? '0 : err_q) | err_new;
    rx_reset_d = (state_d == RECOVER);
    cap_d      = (state_d == CAPTURE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; everything holds while enable is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      in_line_q  <= 1'b0;
      in_frame_q <= 1'b0;
      words_q    <= '0;
      wd_q       <= '0;
      rcnt_q     <= '0;
      perr_q     <= 1'b0;
      lines_q    <= '0;
      err_q      <= '0;
      rx_reset_q <= 1'b0;
      cap_q      <= 1'b0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      fe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else if (bus.enable) begin
      state_q    <= state_d;
      in_line_q  <= bus.in_line;
      in_frame_q <= bus.in_frame;
      words_q    <= words_d;
      wd_q       <= wd_d;
      rcnt_q     <= rcnt_d;
      perr_q     <= perr_d;
      lines_q    <= lines_d;
      err_q      <= err_d;
      rx_reset_q <= rx_reset_d;
      cap_q      <= cap_d;
      fs_q       <= fs_d;
      fd_q       <= fd_d;
      fe_q       <= fe_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.rx_reset       = rx_reset_q;
  assign bus.capture_enable = cap_q;
  assign bus.frame_start    = fs_q;
  assign bus.frame_done     = fd_q;
  assign bus.frame_error    = fe_q;
  assign bus.line_count     = lines_q;
  assign bus.err_flags      = err_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_csi_rx_frame_ctrl.sv
// tb_csi_rx_frame_ctrl: directed scenarios plus randomized frames, checked every
// cycle against a behavioural frame model and pinned with literal expectations.
module tb_csi_rx_frame_ctrl;
  localparam int EL = 4;
  localparam int EW = 3;
  localparam int TO = 20;
  localparam int RC = 4;

  logic clock = 1'b0;
  logic reset;
  csi_rx_frame_ctrl_if bus();

  csi_rx_frame_ctrl #(
    .EXP_LINES   (16'(EL)),
    .EXP_WORDS   (16'(EW)),
    .TIMEOUT     (24'(TO)),
    .RESET_CYCLES(4'(RC))
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  bit rand_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_REC = 3;
  int m_mode, m_words, m_quiet, m_left, m_lines, m_err, m_newerr;
  bit m_pl, m_pf, m_bad, m_valid = 1'b0;
  bit e_rx, e_cap, e_fs, e_fd, e_fe, e_busy;
  bit lend, fend, act, lbad, cbad;

  task automatic m_start();
    e_fs = 1; m_lines = 0; m_words = 0; m_quiet = 0; m_bad = 0; m_mode = M_CAP;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_mode = M_IDLE; m_pl = 0; m_pf = 0; m_words = 0; m_quiet = 0; m_left = 0;
      m_bad = 0; m_lines = 0; m_err = 0;
      e_rx = 0; e_cap = 0; e_fs = 0; e_fd = 0; e_fe = 0; e_busy = 0;
      m_valid = 1;
    end else if (bus.enable) begin
      e_fs = 0; e_fd = 0; e_fe = 0; m_newerr = 0;
      lend = m_pl && !bus.in_line;
      fend = m_pf && !bus.in_frame;
      act  = bus.payload_enable || (bus.in_line != m_pl) ||
             (bus.in_frame != m_pf) || bus.vsync;
      case (m_mode)
        M_IDLE: if (bus.arm || bus.continuous) m_mode = M_WAIT;
        M_WAIT: if (bus.vsync) m_start();
        M_CAP: begin
          if (!act && (m_quiet + 1 >= TO)) begin
            m_newerr |= 4; e_fe = 1; m_mode = M_REC; m_left = RC;
          end else if (bus.vsync) begin
            m_newerr |= 8; e_fe = 1; m_start();
          end else begin
            m_quiet = act ? 0 : m_quiet + 1;
            if (bus.payload_enable && bus.in_line && m_words < 65535) m_words++;
            lbad = 0; cbad = 0;
            if (lend) begin
              m_lines = (m_lines + 1) % 65536;
              lbad = (m_words != EW);
              m_words = 0;
              if (lbad) begin m_newerr |= 1; m_bad = 1; end
            end
            if (fend) begin
              cbad = (m_lines != EL);
              if (cbad) m_newerr |= 2;
              if (m_bad || cbad) e_fe = 1; else e_fd = 1;
              m_mode = bus.continuous ? M_WAIT : M_IDLE;
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = bus.continuous ? M_WAIT : M_IDLE;
        end
      endcase
      m_err  = (bus.clear_err ? 0 : m_err) | m_newerr;
      e_rx   = (m_mode == M_REC);
      e_cap  = (m_mode == M_CAP);
      e_busy = (m_mode != M_IDLE);
      m_pl = bus.in_line;
      m_pf = bus.in_frame;
    end
  end

  // ---------------- compare process ----------------
  int n_fs, n_fd, n_fe, n_cap;
  always @(negedge clock) begin
    if (m_valid) begin
      chk("rx_reset",       int'(bus.rx_reset),       int'(e_rx));
      chk("capture_enable", int'(bus.capture_enable), int'(e_cap));
      chk("frame_start",    int'(bus.frame_start),    int'(e_fs));
      chk("frame_done",     int'(bus.frame_done),     int'(e_fd));
      chk("frame_error",    int'(bus.frame_error),    int'(e_fe));
      chk("line_count",     int'(bus.line_count),     m_lines);
      chk("err_flags",      int'(bus.err_flags),      m_err);
      chk("busy",           int'(bus.busy),           int'(e_busy));
      n_fs  += int'(bus.frame_start);
      n_fd  += int'(bus.frame_done);
      n_fe  += int'(bus.frame_error);
      n_cap += int'(bus.capture_enable);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_en) begin
      bus.enable    = ($urandom_range(7) != 0);
      bus.clear_err = ($urandom_range(31) == 0);
    end
  endtask

  task automatic clr_counts();
    n_fs = 0; n_fd = 0; n_fe = 0; n_cap = 0;
  endtask

  task automatic send_line(input int nw);
    bus.in_line = 1;
    for (int w = 0; w < nw; w++) begin
      if (rand_en && $urandom_range(3) == 0) begin
        bus.payload_enable = 0; tick();
      end
      bus.payload_enable = 1; tick();
    end
    bus.payload_enable = 0; bus.in_line = 0; tick();
  endtask

  task automatic send_frame(input int nl, input int bad_l, input int bad_w,
                            input int fs_l, input int stall_l);
    bus.vsync = 1; tick();
    bus.vsync = 0; bus.in_frame = 1; tick();
    for (int l = 0; l < nl; l++) begin
      if (l == fs_l) begin bus.vsync = 1; tick(); bus.vsync = 0; end
      if (l == stall_l) repeat (TO + RC + 3) tick();
      send_line((l == bad_l) ? bad_w : EW);
    end
    bus.in_frame = 0; tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.enable = 1; bus.arm = 0; bus.continuous = 0; bus.clear_err = 0;
    bus.vsync = 0; bus.in_frame = 0; bus.in_line = 0; bus.payload_enable = 0;
    reset = 1;
    tick(); tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_lines", int'(bus.line_count), 0);
    chk("rst_err", int'(bus.err_flags), 0);
    chk("rst_rx", int'(bus.rx_reset), 0);
    reset = 0; tick();

    // Nominal single-shot frame.
    clr_counts();
    bus.arm = 1; tick(); bus.arm = 0; tick();
    send_frame(EL, -1, 0, -1, -1);
    tick();
    chk("nom_fs_count", n_fs, 1);
    chk("nom_fd_count", n_fd, 1);
    chk("nom_fe_count", n_fe, 0);
    chk("nom_cap_cycles", n_cap, 18);
    chk("nom_lines", int'(bus.line_count), 4);
    chk("nom_err", int'(bus.err_flags), 0);
    chk("nom_busy", int'(bus.busy), 0);

    // Short line 2.
    clr_counts();
    bus.arm = 1; tick(); bus.arm = 0; tick();
    send_frame(EL, 1, 2, -1, -1);
    tick();
    chk("short_err", int'(bus.err_flags), 1);
    chk("short_fe_count", n_fe, 1);
    chk("short_fd_count", n_fd, 0);
    bus.clear_err = 1; tick(); bus.clear_err = 0;
    chk("short_cleared", int'(bus.err_flags), 0);

    // Wrong line count then good frame, continuous.
    clr_counts();
    bus.continuous = 1; tick(); tick();
    send_frame(3, -1, 0, -1, -1);
    tick();
    chk("cnt_err", int'(bus.err_flags), 2);
    chk("cnt_fe_count", n_fe, 1);
    chk("cnt_fd_count", n_fd, 0);
    send_frame(EL, -1, 0, -1, -1);
    tick();
    chk("cnt_fd2_count", n_fd, 1);
    chk("cnt_busy", int'(bus.busy), 1);

    // Timeout with stall after FS.
    bus.clear_err = 1; tick(); bus.clear_err = 0;
    bus.vsync = 1; bus.in_frame = 1; tick();
    chk("to_fs", int'(bus.frame_start), 1);
    bus.vsync = 0;
    repeat (19) tick();
    chk("to_fe_early", int'(bus.frame_error), 0);
    tick();
    chk("to_fe", int'(bus.frame_error), 1);
    chk("to_rx_on", int'(bus.rx_reset), 1);
    repeat (3) tick();
    chk("to_rx_hold", int'(bus.rx_reset), 1);
    tick();
    chk("to_rx_off", int'(bus.rx_reset), 0);
    chk("to_err", int'(bus.err_flags), 4);
    chk("to_busy_wait", int'(bus.busy), 1);
    bus.in_frame = 0; tick();

    // FS without FE.
    bus.continuous = 0;
    clr_counts();
    bus.vsync = 1; tick();
    bus.vsync = 0; bus.in_frame = 1; tick();
    send_line(EW); send_line(EW);
    bus.vsync = 1; tick(); bus.vsync = 0;
    chk("fsfe_fs", int'(bus.frame_start), 1);
    chk("fsfe_fe", int'(bus.frame_error), 1);
    chk("fsfe_err3", int'(bus.err_flags[3]), 1);
    chk("fsfe_lines", int'(bus.line_count), 0);
    for (int l = 0; l < EL; l++) send_line(EW);
    bus.in_frame = 0; tick(); tick();
    chk("fsfe_fd_count", n_fd, 1);
    chk("fsfe_busy", int'(bus.busy), 0);

    // Enable hold mid-line, then reset during RECOVER.
    bus.arm = 1; tick(); bus.arm = 0;
    bus.vsync = 1; tick(); bus.vsync = 0; bus.in_frame = 1; tick();
    bus.in_line = 1; bus.payload_enable = 1; tick(); tick();
    bus.enable = 0;
    for (int i = 0; i < 10; i++) begin
      bus.payload_enable = i[0];
      bus.in_line = i[1];
      tick();
    end
    chk("en_hold_cap", int'(bus.capture_enable), 1);
    chk("en_hold_busy", int'(bus.busy), 1);
    bus.in_line = 1; bus.payload_enable = 0; bus.enable = 1;
    repeat (22) tick();
    chk("en_recover", int'(bus.rx_reset), 1);
    reset = 1; tick(); reset = 0;
    chk("rr_rx", int'(bus.rx_reset), 0);
    chk("rr_cap", int'(bus.capture_enable), 0);
    chk("rr_busy", int'(bus.busy), 0);
    chk("rr_err", int'(bus.err_flags), 0);
    chk("rr_lines", int'(bus.line_count), 0);
    bus.in_line = 0; bus.in_frame = 0; tick();

    // Randomized frames.
    rand_en = 1;
    for (int f = 0; f < 40; f++) begin
      int nl, bl, bw, fl, sl;
      bus.continuous = ($urandom_range(2) == 0);
      bus.arm = 1; tick(); bus.arm = 0;
      repeat ($urandom_range(3)) tick();
      nl = $urandom_range(EL + 1, EL - 1);
      bl = ($urandom_range(3) == 0) ? $urandom_range(nl - 1) : -1;
      bw = $urandom_range(EW + 1, 1);
      fl = ($urandom_range(7) == 0) ? $urandom_range(nl - 1) : -1;
      sl = ($urandom_range(7) == 0) ? $urandom_range(nl - 1) : -1;
      send_frame(nl, bl, bw, fl, sl);
      if ($urandom_range(9) == 0) begin reset = 1; tick(); reset = 0; end
    end
    rand_en = 0;
    bus.enable = 1; bus.clear_err = 0; bus.continuous = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
